// File: rtl/pe_cfg_pkg.sv
// Shared types for PE programming: instruction word, opcodes and sequencer states.
package pe_cfg_pkg;

  localparam int PKG_INSTR_W = 4;

  typedef logic [PKG_INSTR_W-1:0] instr_t;

  localparam instr_t OP_FADD      = 4'b0000;
  localparam instr_t OP_FMUL      = 4'b0001;
  localparam instr_t OP_DATA_ONLY = 4'b0010;
  localparam instr_t OP_FMA       = 4'b0011;
  localparam instr_t OP_SYS_FMA   = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PROG,
    ST_FINISH,
    ST_RUN
  } state_t;

endpackage

// File: rtl/pe_instr_table.sv
// Per-PE compute instruction store: one write port, bulk clear, all entries readable at once.
module pe_instr_table #(
  parameter int NUM_PE  = 12,
  parameter int INSTR_W = 4,
  parameter int ID_W    = $clog2(NUM_PE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [ID_W-1:0]             wr_addr,
  input  logic [INSTR_W-1:0]          wr_data,
  output logic [NUM_PE*INSTR_W-1:0]   rd_all
);

  logic [INSTR_W-1:0] mem [NUM_PE];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_PE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (ID_W'(i) == wr_addr) mem[i] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_rd
    assign rd_all[g*INSTR_W +: INSTR_W] = mem[g];
  end

endmodule

// File: rtl/pe_program_sequencer.sv
// Programs a PE array from a config beat stream (clear, per-PE loads), then holds
// each PE's compute instruction from the internal table during RUN.
//
// state     | meaning
// ST_IDLE   | waiting for start_prog, table retained
// ST_CLEAR  | one-cycle broadcast PE reset, table and cfg_err cleared
// ST_PROG   | accepting config beats, one load per cycle
// ST_FINISH | one-cycle prog_done, last beat's load issues here
// ST_RUN    | PEs compute from table; start_prog reprograms, stop idles
module pe_program_sequencer
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE  = 12,
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 4,
  parameter int ID_W    = $clog2(NUM_PE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_prog,
  input  logic                       stop,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [ID_W-1:0]            cfg_pe_id,
  input  logic [INSTR_W-1:0]         cfg_instr,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic                       cfg_last,
  output logic                       pe_reset,
  output logic [NUM_PE-1:0]          pe_load,
  output logic [NUM_PE*INSTR_W-1:0]  pe_instruction,
  output logic [DATA_W-1:0]          pe_data,
  output logic                       running,
  output logic                       prog_done,
  output logic                       cfg_err
);

  state_t                      state, state_nxt;
  logic                        accept, in_range, tbl_clear, tbl_wr;
  logic [NUM_PE*INSTR_W-1:0]   tbl_rd, instr_nxt;
  logic [NUM_PE-1:0]           load_nxt;

  assign accept    = cfg_valid & cfg_ready;
  // Extra bit keeps the compare valid when NUM_PE is a power of two.
  assign in_range  = {1'b0, cfg_pe_id} < (ID_W+1)'(NUM_PE);
  assign tbl_clear = (state_nxt == ST_CLEAR);
  assign tbl_wr    = accept & in_range & (cfg_instr != INSTR_W'(OP_DATA_ONLY));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_prog) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_PROG;
      ST_PROG:   if (accept && cfg_last) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_RUN;
      ST_RUN: begin
        if (start_prog)  state_nxt = ST_CLEAR;
        else if (stop)   state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The table already holds any write from this edge's beat one cycle later, so
  // only the load cycle needs the beat's own instruction overlaid (data-only case).
  always_comb begin
    load_nxt  = '0;
    instr_nxt = tbl_clear ? '0 : tbl_rd;
    if (accept && in_range) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (ID_W'(i) == cfg_pe_id) begin
          load_nxt[i]                       = 1'b1;
          instr_nxt[i*INSTR_W +: INSTR_W]   = cfg_instr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cfg_ready      <= 1'b0;
      pe_reset       <= 1'b0;
      pe_load        <= '0;
      pe_instruction <= '0;
      pe_data        <= '0;
      running        <= 1'b0;
      prog_done      <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      cfg_ready      <= (state_nxt == ST_PROG);
      pe_reset       <= (state_nxt == ST_CLEAR);
      pe_load        <= load_nxt;
      pe_instruction <= instr_nxt;
      running        <= (state_nxt == ST_RUN);
      prog_done      <= (state_nxt == ST_FINISH);
      if (accept && in_range) pe_data <= cfg_data;
      if (tbl_clear)                 cfg_err <= 1'b0;
      else if (accept && !in_range)  cfg_err <= 1'b1;
    end
  end

  pe_instr_table #(
    .NUM_PE  (NUM_PE),
    .INSTR_W (INSTR_W),
    .ID_W    (ID_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .clear   (tbl_clear),
    .wr_en   (tbl_wr),
    .wr_addr (cfg_pe_id),
    .wr_data (cfg_instr),
    .rd_all  (tbl_rd)
  );

endmodule

// File: tb/tb_pe_program_sequencer.sv
// Directed bench for pe_program_sequencer: load events go through a scoreboard queue,
// table contents are tracked by a small reference array.
module tb_pe_program_sequencer;

  localparam int NUM_PE = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_prog = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_pe_id = '0;
  logic [3:0]  cfg_instr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        pe_reset;
  logic [11:0] pe_load;
  logic [47:0] pe_instruction;
  logic [31:0] pe_data;
  logic        running;
  logic        prog_done;
  logic        cfg_err;

  int total = 0;
  int bad = 0;
  int loads_seen = 0;
  int base;

  typedef struct {
    logic [11:0] load;
    logic [31:0] data;
    logic [3:0]  instr;
    int          id;
  } ld_t;

  ld_t        q[$];
  logic [3:0] tbl_m [NUM_PE];

  pe_program_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start_prog     (start_prog),
    .stop           (stop),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_pe_id      (cfg_pe_id),
    .cfg_instr      (cfg_instr),
    .cfg_data       (cfg_data),
    .cfg_last       (cfg_last),
    .pe_reset       (pe_reset),
    .pe_load        (pe_load),
    .pe_instruction (pe_instruction),
    .pe_data        (pe_data),
    .running        (running),
    .prog_done      (prog_done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] model_flat();
    logic [47:0] f;
    for (int i = 0; i < NUM_PE; i++) f[i*4 +: 4] = tbl_m[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_PE; i++) tbl_m[i] = 4'h0;
  endtask

  task automatic send(input int id, input logic [3:0] ins, input logic [31:0] d,
                      input logic l, input bit hold);
    ld_t e;
    cfg_valid = 1'b1;
    cfg_pe_id = id[3:0];
    cfg_instr = ins;
    cfg_data  = d;
    cfg_last  = l;
    if (id < NUM_PE) begin
      e.load  = 12'b1 << id;
      e.data  = d;
      e.instr = ins;
      e.id    = id;
      q.push_back(e);
      if (ins != 4'b0010) tbl_m[id] = ins;
    end
    tick();
    if (!hold) begin
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
    end
  endtask

  // Monitor: samples mid-cycle, checks invariants and pops the load scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_load_exclusive", {63'd0, pe_reset & (|pe_load)}, 64'd0);
      chk("load_onehot", {63'd0, $countones(pe_load) > 1}, 64'd0);
      if (pe_load != '0) begin
        loads_seen++;
        if (q.size() == 0) begin
          chk("unexpected_load", {52'd0, pe_load}, 64'd0);
        end else begin
          ld_t e;
          e = q.pop_front();
          chk("load_mask", {52'd0, pe_load}, {52'd0, e.load});
          chk("load_data", {32'd0, pe_data}, {32'd0, e.data});
          chk("load_slice", {60'd0, pe_instruction[e.id*4 +: 4]}, {60'd0, e.instr});
        end
      end
    end
  end

  initial begin
    model_clear();

    // Power-on reset
    tick();
    tick();
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_pe_reset", {63'd0, pe_reset}, 64'd0);
    chk("rst_load", {52'd0, pe_load}, 64'd0);
    chk("rst_instr", {16'd0, pe_instruction}, 64'd0);
    chk("rst_data", {32'd0, pe_data}, 64'd0);
    chk("rst_running", {63'd0, running}, 64'd0);
    chk("rst_done", {63'd0, prog_done}, 64'd0);
    chk("rst_err", {63'd0, cfg_err}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", {63'd0, cfg_ready}, 64'd0);

    // Reset mid-PROG with a beat pending
    start_prog = 1'b1;
    tick();
    start_prog = 1'b0;
    chk("t1_clear_pulse", {63'd0, pe_reset}, 64'd1);
    tick();
    chk("t1_prog_ready", {63'd0, cfg_ready}, 64'd1);
    cfg_valid = 1'b1;
    cfg_pe_id = 4'd3;
    cfg_instr = 4'h1;
    cfg_data  = 32'h12345678;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t1_ready", {63'd0, cfg_ready}, 64'd0);
    chk("t1_load", {52'd0, pe_load}, 64'd0);
    chk("t1_data", {32'd0, pe_data}, 64'd0);
    chk("t1_instr", {16'd0, pe_instruction}, 64'd0);
    chk("t1_pe_reset", {63'd0, pe_reset}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_ready_held_low", {63'd0, cfg_ready}, 64'd0);
    end
    cfg_valid = 1'b0;

    // Basic two-beat session
    start_prog = 1'b1;
    tick();
    start_prog = 1'b0;
    model_clear();
    chk("t2_clear_pulse", {63'd0, pe_reset}, 64'd1);
    chk("t2_clear_ready", {63'd0, cfg_ready}, 64'd0);
    tick();
    chk("t2_clear_one_cycle", {63'd0, pe_reset}, 64'd0);
    chk("t2_ready", {63'd0, cfg_ready}, 64'd1);
    send(0, 4'h1, 32'h3F800000, 1'b0, 1'b1);
    send(5, 4'hA, 32'h40000000, 1'b1, 1'b0);
    chk("t2_done", {63'd0, prog_done}, 64'd1);
    chk("t2_finish_ready", {63'd0, cfg_ready}, 64'd0);
    tick();
    chk("t2_running", {63'd0, running}, 64'd1);
    chk("t2_done_pulse", {63'd0, prog_done}, 64'd0);
    chk("t2_run_instr", {16'd0, pe_instruction}, {16'd0, model_flat()});
    chk("t2_slice5", {60'd0, pe_instruction[23:20]}, 64'hA);

    // Data-only load keeps the table entry
    start_prog = 1'b1;
    tick();
    start_prog = 1'b0;
    model_clear();
    chk("t3_clear_instr", {16'd0, pe_instruction}, 64'd0);
    tick();
    send(5, 4'hA, 32'h11111111, 1'b0, 1'b1);
    send(5, 4'h2, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("t3_data", {32'd0, pe_data}, 64'hDEADBEEF);
    tick();
    chk("t3_run_instr", {16'd0, pe_instruction}, {16'd0, model_flat()});
    chk("t3_slice5", {60'd0, pe_instruction[23:20]}, 64'hA);
    chk("t3_data_hold", {32'd0, pe_data}, 64'hDEADBEEF);

    // Out-of-range id
    start_prog = 1'b1;
    tick();
    start_prog = 1'b0;
    model_clear();
    tick();
    send(13, 4'h1, 32'hCAFE0000, 1'b1, 1'b0);
    chk("t4_err", {63'd0, cfg_err}, 64'd1);
    chk("t4_no_load", {52'd0, pe_load}, 64'd0);
    tick();
    chk("t4_err_sticky", {63'd0, cfg_err}, 64'd1);
    chk("t4_table", {16'd0, pe_instruction}, {16'd0, model_flat()});
    chk("t4_data_kept", {32'd0, pe_data}, 64'hDEADBEEF);
    tick();
    chk("t4_err_sticky2", {63'd0, cfg_err}, 64'd1);
    start_prog = 1'b1;
    tick();
    start_prog = 1'b0;
    model_clear();
    chk("t4_err_cleared", {63'd0, cfg_err}, 64'd0);
    chk("t4_clear_pulse", {63'd0, pe_reset}, 64'd1);
    tick();

    // Twelve back-to-back beats
    base = loads_seen;
    for (int i = 0; i < NUM_PE; i++) begin
      chk("t5_ready", {63'd0, cfg_ready}, 64'd1);
      send(i, 4'(i + 3), 32'h1000 + 32'(i), i == NUM_PE - 1, 1'b1);
      chk("t5_no_bubble", 64'(loads_seen), 64'(base + i));
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("t5_finish", {63'd0, prog_done}, 64'd1);
    tick();
    chk("t5_all_loads", 64'(loads_seen), 64'(base + NUM_PE));
    chk("t5_running", {63'd0, running}, 64'd1);
    chk("t5_run_instr", {16'd0, pe_instruction}, {16'd0, model_flat()});

    // start_prog and stop together: start wins, table zeroed
    start_prog = 1'b1;
    stop = 1'b1;
    tick();
    start_prog = 1'b0;
    stop = 1'b0;
    model_clear();
    chk("t6_clear_pulse", {63'd0, pe_reset}, 64'd1);
    chk("t6_not_running", {63'd0, running}, 64'd0);
    chk("t6_table_zero", {16'd0, pe_instruction}, 64'd0);
    tick();
    send(4, 4'h3, 32'hABCD0123, 1'b1, 1'b0);
    tick();
    chk("t6_running", {63'd0, running}, 64'd1);

    // stop alone: IDLE with table retained
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stop_running", {63'd0, running}, 64'd0);
    chk("t6_stop_ready", {63'd0, cfg_ready}, 64'd0);
    chk("t6_idle_instr", {16'd0, pe_instruction}, {16'd0, model_flat()});
    tick();
    tick();
    chk("t6_idle_instr_kept", {16'd0, pe_instruction}, {16'd0, model_flat()});
    chk("t6_slice4", {60'd0, pe_instruction[19:16]}, 64'h3);
    chk("t6_idle_data", {32'd0, pe_data}, 64'hABCD0123);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_program_sequencer.md
Name: pe_program_sequencer

Overview:
- Upstream control stage for a row/array of PEs.
- Consumes a valid/ready stream of configuration beats and performs the programming phase: a one-cycle PE clear, then per-PE `load` pulses carrying instruction and internal data.
- After programming it enters the run phase and holds each PE's compute instruction from an internal per-PE table.
- Owns every PE's `reset`, `load`, `instruction` and `internal_data_in` pins.

Parameters:
- NUM_PE, 12, number of PEs driven; must be ≥ 2.
- DATA_W, 32, width of internal data word.
- INSTR_W, 4, width of PE instruction.
- ID_W, $clog2(NUM_PE), width of the PE index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start_prog  in  1  begins a programming session; accepted only in IDLE or RUN.
- stop  in  1  leaves RUN.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat ready.
- cfg_pe_id  in  ID_W  target PE index.
- cfg_instr  in  INSTR_W  instruction for the target PE.
- cfg_data  in  DATA_W  internal data for the target PE.
- cfg_last  in  1  final beat of the session.
- pe_reset  out  1  broadcast PE reset.
- pe_load  out  NUM_PE  one-hot-or-zero load strobes.
- pe_instruction  out  NUM_PE*INSTR_W  per-PE instruction; slice i drives PE i.
- pe_data  out  DATA_W  broadcast internal_data_in.
- running  out  1  high while in RUN.
- prog_done  out  1  one-cycle pulse at the end of a session.
- cfg_err  out  1  sticky flag: out-of-range cfg_pe_id seen.

Behaviour:
- Reset (any state, including mid-session):
  - State goes to IDLE.
  - All outputs 0: cfg_ready, pe_reset, pe_load, pe_instruction, pe_data, running, prog_done, cfg_err.
  - Instruction table cleared to 0 (matches PE post-reset config 0 = Fadd).
- FSM states: IDLE, CLEAR, PROG, FINISH, RUN. All transitions take effect on clk.
- IDLE:
  - cfg_ready=0.
  - start_prog → CLEAR.
- CLEAR (exactly 1 cycle):
  - pe_reset=1, cfg_ready=0.
  - Table cleared to 0; cfg_err cleared.
  - Next state PROG.
- PROG:
  - cfg_ready=1. A beat is accepted when cfg_valid&cfg_ready in cycle T.
  - In cycle T+1, when cfg_pe_id < NUM_PE:
    - pe_load[cfg_pe_id]=1, all other bits 0.
    - pe_data=cfg_data.
    - Slice cfg_pe_id of pe_instruction = cfg_instr.
  - Table update: table[cfg_pe_id] is written with cfg_instr unless cfg_instr == 4'b0010. 0010 is a data-only load; the PE keeps its configuration, and the table mirrors that.
  - After the T+1 load cycle, pe_instruction slice id reverts to the table value.
  - Out-of-range cfg_pe_id:
    - Beat is still consumed.
    - No pe_load bit set; table unchanged.
    - cfg_err set (sticky until the next CLEAR).
  - Back-to-back beats are supported: one load per cycle at full throughput.
  - Accepted beat with cfg_last=1 → FINISH. Its load still issues in the FINISH cycle.
  - start_prog and stop are ignored in PROG.
- FINISH (1 cycle):
  - cfg_ready=0, prog_done=1.
  - Next state RUN.
- RUN:
  - running=1, cfg_ready=0, pe_load=0.
  - pe_instruction = full table; pe_data holds its last value.
  - start_prog → CLEAR (start_prog wins when asserted together with stop).
  - stop alone → IDLE.
- Outside the load cycle, every pe_instruction slice equals its table entry. In IDLE this means the table is retained from the previous session.
- pe_load never has more than one bit set.
- pe_reset and pe_load are never high in the same cycle.
- All outputs are registered.

Decomposition:
- Shared package pe_cfg_pkg:
  - Instruction typedef (INSTR_W).
  - Opcode constants: OP_FADD=4'b0000, OP_FMUL=4'b0001, OP_SYS_FMA=4'b1010, OP_FMA=4'b0011, OP_DATA_ONLY=4'b0010.
  - FSM state enum.
- Sub-module: pe_instr_table (NUM_PE×INSTR_W register file with a clear input, one write port, and a flattened read-all output).
- The FSM and beat handling live in the top.

Test Plan:
- Reset mid-PROG with a beat pending → next cycle all outputs 0, state IDLE, and cfg_ready stays 0 until start_prog followed by CLEAR.
- start_prog, then beats {id 0, 4'b0001, 32'h3F800000}, {id 5, 4'b1010, 32'h40000000, last}:
  - pe_reset pulses 1 cycle.
  - pe_load = 12'h001, then 12'h020 in consecutive cycles, with matching pe_data.
  - prog_done pulses; running=1.
  - pe_instruction slices: 0 = 1, 5 = A, others 0.
- Beat {id 5, 4'b0010, 32'hDEADBEEF} after {id 5, 4'b1010} → pe_load[5] pulses with pe_data = DEADBEEF, and table slice 5 stays 4'hA.
- Beat with id 13 (out of range) → no pe_load, cfg_err=1 and held; a later start_prog clears it in CLEAR.
- cfg_valid held continuously for 12 beats, ids 0..11, the last flagged cfg_last:
  - One load per cycle, no bubbles.
  - FINISH arrives exactly 1 cycle after the final acceptance.
- In RUN:
  - start_prog and stop asserted together → CLEAR, and the table is zeroed.
  - stop alone → IDLE, running=0, table retained.
